// File: rtl/stream_req_arbiter.sv
// rtl/stream_req_arbiter.sv - per-master round-robin packet arbiter for a stream crossbar
//
// Decodes each slave port's destination into per-master requests. Each master
// port runs its own IDLE/LOCKED FSM. A master picks a requesting slave
// round-robin and keeps the grant until the tlast beat of that slave's packet
// is accepted. The registered grants drive the crossbar mux selects and the
// valid/ready gating.
//
// Optional feature: define STREAM_REQ_ARBITER_DEST_ERR_EN to add dest_err_o.
// dest_err_o holds one sticky flag per slave that presented an out-of-range dest.
//
// Ports:
//    clk_i       - clock; all state changes on the rising edge
//    rst_i       - asynchronous active-high reset
//    s_dest_i    - per-slave destination, slave s in [s*T_DEST_WIDTH +: T_DEST_WIDTH]
//    s_valid_i   - per-slave tvalid
//    s_last_i    - per-slave tlast
//    m_ready_i   - per-master tready from downstream
//    grant_o     - registered grants, bit m*S_DATA_COUNT+s = master m locked to slave s
//    m_valid_o   - gated tvalid toward each master
//    s_ready_o   - gated tready back to each slave
//    dest_err_o  - (optional) sticky out-of-range destination flags per slave
`timescale 1ns/1ps

module stream_req_arbiter #(
   parameter int  S_DATA_COUNT = 2,
   parameter int  M_DATA_COUNT = 3,
   localparam int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
   input  logic [S_DATA_COUNT-1:0]              s_valid_i,
   input  logic [S_DATA_COUNT-1:0]              s_last_i,
   input  logic [M_DATA_COUNT-1:0]              m_ready_i,
   output logic [M_DATA_COUNT*S_DATA_COUNT-1:0] grant_o,
   output logic [M_DATA_COUNT-1:0]              m_valid_o,
   output logic [S_DATA_COUNT-1:0]              s_ready_o
`ifdef STREAM_REQ_ARBITER_DEST_ERR_EN
   ,
   output logic [S_DATA_COUNT-1:0]              dest_err_o
`endif
);

   localparam int GIDX_WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                                state_q [M_DATA_COUNT];
   state_t                                state_d [M_DATA_COUNT];
   logic [GIDX_WIDTH-1:0]                 gidx_q  [M_DATA_COUNT];
   logic [GIDX_WIDTH-1:0]                 gidx_d  [M_DATA_COUNT];
   logic [GIDX_WIDTH-1:0]                 ptr_q   [M_DATA_COUNT];
   logic [GIDX_WIDTH-1:0]                 ptr_d   [M_DATA_COUNT];
   logic [M_DATA_COUNT*S_DATA_COUNT-1:0]  grant_q;
   logic [M_DATA_COUNT*S_DATA_COUNT-1:0]  grant_d;
   logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req;

   // A dest value of M_DATA_COUNT or more matches no master, so that slave stalls.
   always_comb begin : req_decode
      req = '0;
      for (int m = 0; m < M_DATA_COUNT; m++) begin
         for (int s = 0; s < S_DATA_COUNT; s++) begin
            req[m][s] = s_valid_i[s] &&
                        (int'(s_dest_i[s*T_DEST_WIDTH +: T_DEST_WIDTH]) == m);
         end
      end
   end

   always_comb begin : fsm_next
      logic found;
      int   idx;
      found     = 1'b0;
      idx       = 0;
      grant_d   = '0;
      m_valid_o = '0;
      for (int m = 0; m < M_DATA_COUNT; m++) begin
         state_d[m] = state_q[m];
         gidx_d[m]  = gidx_q[m];
         ptr_d[m]   = ptr_q[m];
         case (state_q[m])
            IDLE: begin
               // The scan starts at ptr and wraps. The first requester found wins.
               found = 1'b0;
               for (int k = 0; k < S_DATA_COUNT; k++) begin
                  idx = (int'(ptr_q[m]) + k) % S_DATA_COUNT;
                  if (!found && req[m][idx]) begin
                     found     = 1'b1;
                     gidx_d[m] = GIDX_WIDTH'(idx);
                  end
               end
               if (found) begin
                  state_d[m] = LOCKED;
               end
            end
            LOCKED: begin
               m_valid_o[m] = s_valid_i[gidx_q[m]];
               if (s_valid_i[gidx_q[m]] && m_ready_i[m] && s_last_i[gidx_q[m]]) begin
                  state_d[m] = IDLE;
                  ptr_d[m]   = GIDX_WIDTH'((int'(gidx_q[m]) + 1) % S_DATA_COUNT);
               end
            end
            default: state_d[m] = IDLE;
         endcase
         // Grants come from next-state so that grant_o is a plain register output.
         if (state_d[m] == LOCKED) begin
            grant_d[m*S_DATA_COUNT + int'(gidx_d[m])] = 1'b1;
         end
      end
   end

   // A slave presents one dest, so in practice only one master drives its ready.
   always_comb begin : ready_gate
      s_ready_o = '0;
      for (int m = 0; m < M_DATA_COUNT; m++) begin
         if (state_q[m] == LOCKED) begin
            s_ready_o[gidx_q[m]] = s_ready_o[gidx_q[m]] | m_ready_i[m];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin : fsm_regs
      if (rst_i) begin
         for (int m = 0; m < M_DATA_COUNT; m++) begin
            state_q[m] <= IDLE;
            gidx_q[m]  <= '0;
            ptr_q[m]   <= '0;
         end
         grant_q <= '0;
      end else begin
         for (int m = 0; m < M_DATA_COUNT; m++) begin
            state_q[m] <= state_d[m];
            gidx_q[m]  <= gidx_d[m];
            ptr_q[m]   <= ptr_d[m];
         end
         grant_q <= grant_d;
      end
   end

   assign grant_o = grant_q;

`ifdef STREAM_REQ_ARBITER_DEST_ERR_EN
   logic [S_DATA_COUNT-1:0] dest_err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin : dest_err_regs
      if (rst_i) begin
         dest_err_q <= '0;
      end else begin
         for (int s = 0; s < S_DATA_COUNT; s++) begin
            if (s_valid_i[s] &&
                (int'(s_dest_i[s*T_DEST_WIDTH +: T_DEST_WIDTH]) >= M_DATA_COUNT)) begin
               dest_err_q[s] <= 1'b1;
            end
         end
      end
   end

   assign dest_err_o = dest_err_q;
`endif

endmodule
